// File: rtl/fp32_add_cntrl.sv
// fp32_add_cntrl: IEEE-754 single-precision add/sub sequencer, round-to-nearest-even.
// Ports:
//   CLK, RSTn            clock, synchronous active-low reset
//   Datain1/2, Mode      operands A, B; Mode 001 = A-B, anything else = A+B
//   Data_valid           caller request, held until Dataout_valid
//   Dataout, Exc         result word and its class (from the checker)
//   Dataout_valid        result valid, held until Data_valid drops
//   Adder_*              4-phase link to the external 24-bit significand adder
//   ExcCheck_*, Exc_*    4-phase link to the external result classifier
//   Debug, Adder_Exc     reserved / ignored
module fp32_add_cntrl (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [31:0] Datain1,
    input  logic [31:0] Datain2,
    input  logic        Data_valid,
    input  logic [2:0]  Mode,
    input  logic [4:0]  Debug,
    output logic [31:0] Dataout,
    output logic        Dataout_valid,
    output logic [2:0]  Exc,
    output logic [23:0] Adder_datain1,
    output logic [23:0] Adder_datain2,
    output logic        Adder_valid,
    input  logic [23:0] Adder_dataout,
    input  logic        Adder_carryout,
    input  logic        Adder_ack,
    input  logic [2:0]  Adder_Exc,
    output logic        ExcCheck_valid,
    output logic [31:0] ExcCheck_Datain,
    input  logic [2:0]  Exc_value,
    input  logic        Exc_Ack
);
    typedef enum logic [3:0] {IDLE, ALIGN, ADD_REQ, ADD_WAIT, NORM, ROUND, EXC_REQ, EXC_WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [2:0]  mode_q, mode_d;
    logic        sx_q, sx_d, sub_q, sub_d, carry_q, carry_d;
    logic [2:0]  grs_q, grs_d;
    logic [9:0]  ex_q, ex_d;
    logic [23:0] sum_q, sum_d;
    logic [26:0] mant_q, mant_d;
    logic [31:0] dout_q, dout_d, chk_data_q, chk_data_d;
    logic        dout_valid_q, dout_valid_d, add_valid_q, add_valid_d, chk_valid_q, chk_valid_d;
    logic [2:0]  exc_q, exc_d;
    logic [23:0] add_d1_q, add_d1_d, add_d2_q, add_d2_d;

    logic unused;
    assign unused = ^{Debug, Adder_Exc};

    // Alignment: X is the larger magnitude, Y is shifted into {sig,G,R,S}
    logic        sb_eff, swap, eff_sub, lost, special;
    logic [31:0] xw, yw, spec_res;
    logic [7:0]  xe, ye, dd;
    logic [23:0] xs, ys, add_op2;
    logic [26:0] yext, yshr, y_al;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign sb_eff  = b_q[31] ^ (mode_q == 3'b001);
    assign swap    = b_q[30:0] > a_q[30:0];
    assign xw      = swap ? {sb_eff, b_q[30:0]} : a_q;
    assign yw      = swap ? a_q : {sb_eff, b_q[30:0]};
    assign xe      = (xw[30:23] == 8'd0) ? 8'd1 : xw[30:23];
    assign ye      = (yw[30:23] == 8'd0) ? 8'd1 : yw[30:23];
    assign xs      = {xw[30:23] != 8'd0, xw[22:0]};
    assign ys      = {yw[30:23] != 8'd0, yw[22:0]};
    assign dd      = xe - ye;
    assign yext    = {ys, 3'b000};
    assign yshr    = yext >> dd[4:0];
    assign lost    = |(yext & ~(27'h7FFFFFF << dd[4:0]));
    assign y_al    = (dd >= 8'd26) ? {26'd0, |ys} : {yshr[26:1], yshr[0] | lost};
    assign eff_sub = xw[31] ^ yw[31];
    // Subtraction as X + two's complement of Y: the GRS part is negated locally,
    // and its carry into the upper 24 bits exists only when GRS is zero.
    assign add_op2 = eff_sub ? ~y_al[26:3] + {23'd0, y_al[2:0] == 3'd0} : y_al[26:3];

    assign a_nan   = (&a_q[30:23]) & (|a_q[22:0]);
    assign b_nan   = (&b_q[30:23]) & (|b_q[22:0]);
    assign a_inf   = (&a_q[30:23]) & ~(|a_q[22:0]);
    assign b_inf   = (&b_q[30:23]) & ~(|b_q[22:0]);
    assign a_zero  = a_q[30:0] == 31'd0;
    assign b_zero  = b_q[30:0] == 31'd0;
    assign special = a_nan | b_nan | a_inf | b_inf | (a_zero & b_zero);
    assign spec_res = (a_nan | b_nan | (a_inf & b_inf & (a_q[31] != sb_eff))) ? 32'h7FC00000 :
                      a_inf ? a_q :
                      b_inf ? {sb_eff, b_q[30:0]} :
                      {a_q[31] & sb_eff, 31'd0};

    // Normalisation
    logic [26:0] diff, norm_mant;
    logic [27:0] add_full;
    logic [4:0]  lz;
    logic [9:0]  lim, sh, norm_exp;
    logic        norm_zero;

    assign diff = {sum_q, 3'd0 - grs_q};
    always_comb begin
        lz = 5'd27;
        for (int i = 0; i < 27; i++)
            if (diff[i]) lz = 5'(26 - i);
    end
    // Left shift stops at exp=1 so small differences come out denormal
    assign lim       = ex_q - 10'd1;
    assign sh        = ({5'd0, lz} < lim) ? {5'd0, lz} : lim;
    assign add_full  = {carry_q, sum_q, grs_q};
    assign norm_zero = sub_q & (diff == 27'd0);
    assign norm_mant = sub_q ? diff << sh[4:0] :
                       carry_q ? {add_full[27:2], |add_full[1:0]} : {sum_q, grs_q};
    assign norm_exp  = sub_q ? ex_q - sh : ex_q + {9'd0, carry_q};

    // Rounding (RNE); a denormal result always carries exp=1 here, encoded as 0
    logic        up;
    logic [24:0] rs;
    logic [23:0] rsig;
    logic [9:0]  rexp;
    logic [31:0] round_res;

    assign up        = mant_q[2] & (mant_q[3] | mant_q[1] | mant_q[0]);
    assign rs        = {1'b0, mant_q[26:3]} + {24'd0, up};
    assign rsig      = rs[24] ? rs[24:1] : rs[23:0];
    assign rexp      = ex_q + {9'd0, rs[24]};
    assign round_res = (rexp >= 10'd255) ? {sx_q, 8'hFF, 23'd0} :
                       {sx_q, rsig[23] ? rexp[7:0] : 8'h00, rsig[22:0]};

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        mode_d       = mode_q;
        sx_d         = sx_q;
        sub_d        = sub_q;
        carry_d      = carry_q;
        grs_d        = grs_q;
        ex_d         = ex_q;
        sum_d        = sum_q;
        mant_d       = mant_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        exc_d        = exc_q;
        add_valid_d  = add_valid_q;
        add_d1_d     = add_d1_q;
        add_d2_d     = add_d2_q;
        chk_valid_d  = chk_valid_q;
        chk_data_d   = chk_data_q;
        case (state_q)
            IDLE: if (Data_valid) begin
                a_d     = Datain1;
                b_d     = Datain2;
                mode_d  = Mode;
                state_d = ALIGN;
            end
            ALIGN: begin
                sx_d  = xw[31];
                sub_d = eff_sub;
                grs_d = y_al[2:0];
                ex_d  = {2'd0, xe};
                if (special) begin
                    chk_data_d  = spec_res;
                    chk_valid_d = 1'b1;
                    state_d     = EXC_REQ;
                end else begin
                    add_d1_d    = xs;
                    add_d2_d    = add_op2;
                    add_valid_d = 1'b1;
                    state_d     = ADD_REQ;
                end
            end
            ADD_REQ: if (Adder_ack) begin
                sum_d       = Adder_dataout;
                carry_d     = Adder_carryout;
                add_valid_d = 1'b0;
                state_d     = ADD_WAIT;
            end
            ADD_WAIT: if (!Adder_ack) state_d = NORM;
            NORM: begin
                mant_d  = norm_mant;
                ex_d    = norm_exp;
                sx_d    = sx_q & ~norm_zero;
                state_d = ROUND;
            end
            ROUND: begin
                chk_data_d  = round_res;
                chk_valid_d = 1'b1;
                state_d     = EXC_REQ;
            end
            EXC_REQ: if (Exc_Ack) begin
                exc_d       = Exc_value;
                chk_valid_d = 1'b0;
                state_d     = EXC_WAIT;
            end
            EXC_WAIT: if (!Exc_Ack) begin
                dout_d       = chk_data_q;
                dout_valid_d = 1'b1;
                state_d      = DONE;
            end
            DONE: if (!Data_valid) begin
                dout_valid_d = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            mode_q       <= '0;
            sx_q         <= 1'b0;
            sub_q        <= 1'b0;
            carry_q      <= 1'b0;
            grs_q        <= '0;
            ex_q         <= '0;
            sum_q        <= '0;
            mant_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            exc_q        <= '0;
            add_valid_q  <= 1'b0;
            add_d1_q     <= '0;
            add_d2_q     <= '0;
            chk_valid_q  <= 1'b0;
            chk_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            mode_q       <= mode_d;
            sx_q         <= sx_d;
            sub_q        <= sub_d;
            carry_q      <= carry_d;
            grs_q        <= grs_d;
            ex_q         <= ex_d;
            sum_q        <= sum_d;
            mant_q       <= mant_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            exc_q        <= exc_d;
            add_valid_q  <= add_valid_d;
            add_d1_q     <= add_d1_d;
            add_d2_q     <= add_d2_d;
            chk_valid_q  <= chk_valid_d;
            chk_data_q   <= chk_data_d;
        end
    end

    assign Dataout         = dout_q;
    assign Dataout_valid   = dout_valid_q;
    assign Exc             = exc_q;
    assign Adder_datain1   = add_d1_q;
    assign Adder_datain2   = add_d2_q;
    assign Adder_valid     = add_valid_q;
    assign ExcCheck_valid  = chk_valid_q;
    assign ExcCheck_Datain = chk_data_q;
endmodule

// File: tb/tb_fp32_add_cntrl.sv
// tb_fp32_add_cntrl: randomized self-checking bench against an exact-arithmetic fp32 add model.
module tb_fp32_add_cntrl;
    logic        CLK = 1'b0;
    logic        RSTn;
    logic [31:0] Datain1, Datain2, Dataout, ExcCheck_Datain;
    logic        Data_valid, Dataout_valid, Adder_valid, Adder_carryout, Adder_ack;
    logic        ExcCheck_valid, Exc_Ack;
    logic [2:0]  Mode, Exc, Adder_Exc, Exc_value;
    logic [4:0]  Debug;
    logic [23:0] Adder_datain1, Adder_datain2, Adder_dataout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    fp32_add_cntrl dut (
        .CLK(CLK), .RSTn(RSTn), .Datain1(Datain1), .Datain2(Datain2), .Data_valid(Data_valid),
        .Mode(Mode), .Debug(Debug), .Dataout(Dataout), .Dataout_valid(Dataout_valid), .Exc(Exc),
        .Adder_datain1(Adder_datain1), .Adder_datain2(Adder_datain2), .Adder_valid(Adder_valid),
        .Adder_dataout(Adder_dataout), .Adder_carryout(Adder_carryout), .Adder_ack(Adder_ack),
        .Adder_Exc(Adder_Exc), .ExcCheck_valid(ExcCheck_valid), .ExcCheck_Datain(ExcCheck_Datain),
        .Exc_value(Exc_value), .Exc_Ack(Exc_Ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] classify(input logic [31:0] w);
        if (w[30:23] == 8'hFF) return (w[22:0] != 0) ? 3'b100 : 3'b011;
        if (w[30:23] == 8'h00) return (w[22:0] == 0) ? 3'b001 : 3'b010;
        return 3'b000;
    endfunction

    // Magnitude as an exact integer in units of 2^-149
    function automatic logic [299:0] mag_of(input logic [31:0] x);
        logic [299:0] r;
        r = {276'd0, x[30:23] != 8'd0, x[22:0]};
        return (x[30:23] == 8'd0) ? r : r << (int'(x[30:23]) - 1);
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b0, input logic [2:0] m);
        logic [31:0]  b;
        logic [299:0] ma, mb, mag, q, rem, half;
        logic         s;
        int           p, shf, e;
        b = b0 ^ {(m == 3'd1), 31'd0};
        if ((&a[30:23] && a[22:0] != 0) || (&b[30:23] && b[22:0] != 0)) return 32'h7FC00000;
        if (&a[30:23] && &b[30:23]) return (a[31] != b[31]) ? 32'h7FC00000 : a;
        if (&a[30:23]) return a;
        if (&b[30:23]) return b;
        if (a[30:0] == 0 && b[30:0] == 0) return {a[31] & b[31], 31'd0};
        ma = mag_of(a);
        mb = mag_of(b);
        if (a[31] == b[31]) begin mag = ma + mb; s = a[31]; end
        else if (ma >= mb) begin mag = ma - mb; s = a[31]; end
        else begin mag = mb - ma; s = b[31]; end
        if (mag == 0) return 32'd0;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        if (p <= 23) return {s, 7'd0, mag[23:0]};
        shf  = p - 23;
        q    = mag >> shf;
        rem  = mag - (q << shf);
        half = 300'd1 << (shf - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q[24]) begin q = q >> 1; shf++; end
        e = shf + 1;
        if (e >= 255) return {s, 8'hFF, 23'd0};
        return {s, 8'(e), q[22:0]};
    endfunction

    // Adder callee: 4-phase, random response delays
    initial begin
        Adder_ack = 1'b0; Adder_dataout = '0; Adder_carryout = 1'b0; Adder_Exc = '0;
        forever begin
            @(negedge CLK);
            if (Adder_valid && !Adder_ack) begin
                repeat ($urandom_range(0, 2)) @(negedge CLK);
                {Adder_carryout, Adder_dataout} = {1'b0, Adder_datain1} + {1'b0, Adder_datain2};
                Adder_Exc = 3'($urandom);
                Adder_ack = 1'b1;
            end else if (!Adder_valid && Adder_ack) begin
                repeat ($urandom_range(0, 1)) @(negedge CLK);
                Adder_ack = 1'b0;
            end
        end
    end

    // Exception checker callee
    initial begin
        Exc_Ack = 1'b0; Exc_value = '0;
        forever begin
            @(negedge CLK);
            if (ExcCheck_valid && !Exc_Ack) begin
                repeat ($urandom_range(0, 2)) @(negedge CLK);
                Exc_value = classify(ExcCheck_Datain);
                Exc_Ack = 1'b1;
            end else if (!ExcCheck_valid && Exc_Ack) begin
                repeat ($urandom_range(0, 1)) @(negedge CLK);
                Exc_Ack = 1'b0;
            end
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m, input string tag);
        logic [31:0] e;
        int t;
        e = ref_add(a, b, m);
        @(negedge CLK);
        Datain1 = a; Datain2 = b; Mode = m; Debug = 5'($urandom); Data_valid = 1'b1;
        t = 0;
        while (!Dataout_valid && t < 200) begin @(negedge CLK); t++; end
        if (!Dataout_valid) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            Data_valid = 1'b0;
            return;
        end
        check(tag, Dataout, e);
        check({tag, "_exc"}, {29'd0, Exc}, {29'd0, classify(e)});
        Data_valid = 1'b0;
        Datain1 = 32'($urandom); Datain2 = 32'($urandom);
        @(negedge CLK);
        check({tag, "_vdrop"}, {31'd0, Dataout_valid}, 32'd0);
        check({tag, "_hold"}, Dataout, e);
        repeat ($urandom_range(0, 2)) @(negedge CLK);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_dout"}, Dataout, 32'd0);
        check({tag, "_vals"}, {29'd0, Dataout_valid, Adder_valid, ExcCheck_valid}, 32'd0);
        check({tag, "_exc"}, {29'd0, Exc}, 32'd0);
    endtask

    task automatic reset_mid(input bit at_exc, input string tag);
        int t;
        @(negedge CLK);
        Datain1 = 32'h40300000; Datain2 = 32'h40B00000; Mode = 3'd0; Data_valid = 1'b1;
        t = 0;
        while (!(at_exc ? ExcCheck_valid : Adder_valid) && t < 50) begin @(negedge CLK); t++; end
        check({tag, "_reached"}, {31'd0, at_exc ? ExcCheck_valid : Adder_valid}, 32'd1);
        RSTn = 1'b0; Data_valid = 1'b0;
        @(negedge CLK);
        check_idle_outputs(tag);
        RSTn = 1'b1;
        repeat (8) @(negedge CLK);
    endtask

    function automatic logic [31:0] rnd_fp();
        logic [31:0] sp [6];
        sp = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'h7F7FFFFF};
        case ($urandom_range(0, 5))
            0: return 32'($urandom);
            1: return {1'($urandom), 8'h00, 23'($urandom)};
            2: return sp[$urandom_range(0, 5)];
            default: return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
        endcase
    endfunction

    initial begin
        logic [31:0] a, b;
        logic [31:0] dv [6][3];
        RSTn = 1'b0; Data_valid = 1'b0; Datain1 = '0; Datain2 = '0; Mode = '0; Debug = '0;
        repeat (3) @(negedge CLK);
        check_idle_outputs("reset");
        RSTn = 1'b1;
        repeat (2) @(negedge CLK);

        dv = '{'{32'h40300000, 32'h40B00000, 32'd0}, '{32'hC0300000, 32'h40B00000, 32'd0},
               '{32'h40300000, 32'hC0B00000, 32'd0}, '{32'h402013D3, 32'hC756D800, 32'd0},
               '{32'h42140000, 32'hC2480000, 32'd0}, '{32'h7F800000, 32'hFF800000, 32'd0}};
        foreach (dv[i]) run_op(dv[i][0], dv[i][1], dv[i][2][2:0], $sformatf("dir%0d", i));
        run_op(32'h40B00000, 32'h40300000, 3'd1, "sub_mode");
        run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 3'd0, "overflow");
        run_op(32'h80000000, 32'h80000000, 3'd0, "negzero");
        run_op(32'h80000000, 32'h00000000, 3'd0, "mixzero");
        run_op(32'h3F800000, 32'h3F800000, 3'd1, "exactzero");
        run_op(32'h00400000, 32'h00400001, 3'd0, "denorm_add");
        run_op(32'h00800000, 32'h00000001, 3'd1, "denorm_sub");
        run_op(32'h3F800000, 32'h33800000, 3'd0, "tie_even");
        run_op(32'h3F800001, 32'h33800000, 3'd0, "tie_odd");
        run_op(32'hFF800000, 32'h3F800000, 3'd5, "inf_op");

        reset_mid(1'b0, "rst_add");
        run_op(32'h40300000, 32'h40B00000, 3'd0, "after_rst");
        reset_mid(1'b1, "rst_exc");

        for (int n = 0; n < 400; n++) begin
            a = rnd_fp();
            case ($urandom_range(0, 3))
                0: b = a ^ 32'h80000000 ^ 32'($urandom_range(0, 3));
                1: b = {1'($urandom), a[30:23], 23'($urandom)};
                default: b = rnd_fp();
            endcase
            run_op(a, b, 3'($urandom), $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
